// File: rtl/cellrv32_package.sv
// Shared definitions for the cellrv32 CPU co-processor scheduler:
// FSM state type, default timeout width and co-processor slot assignment.
package cellrv32_package;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        CAPT = 2'b10
    } cp_sched_state_t;

    localparam int CP_SCHED_TMO_BITS_C = 7;

    // Co-processor slot map
    localparam int CP_SEL_SHIFT_C    = 0;
    localparam int CP_SEL_MULDIV_C   = 1;
    localparam int CP_SEL_BITMANIP_C = 2;
    localparam int CP_SEL_FPU_C      = 3;
    localparam int CP_SEL_CFU_C      = 4;
    localparam int CP_SEL_COND_C     = 5;
    localparam int CP_SEL_CRYPTO_C   = 6;
    localparam int CP_SEL_CUSTOM_C   = 7;

endpackage

// File: rtl/cellrv32_cpu_cp_resmux.sv
// Combinational NUM_CP-to-1 selector for co-processor valid flags and results,
// indexed by the latched slot number.
module cellrv32_cpu_cp_resmux #(
    parameter  int XLEN   = 32,
    parameter  int NUM_CP = 8,
    localparam int SEL_W  = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
) (
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [NUM_CP-1:0]      valid_i,
    input  logic [NUM_CP*XLEN-1:0] res_i,
    output logic                   valid_o,
    output logic [XLEN-1:0]        res_o
);

    always_comb begin
        valid_o = 1'b0;
        res_o   = '0;
        for (int unsigned i = 0; i < NUM_CP; i++) begin
            if (sel_i == SEL_W'(i)) begin
                valid_o = valid_i[i];
                res_o   = res_i[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/cellrv32_cpu_cp_sched.sv
// Co-processor dispatcher: validates the requested slot, holds its start line,
// captures the result one cycle after valid, and guards with timeout/abort.
module cellrv32_cpu_cp_sched
    import cellrv32_package::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NUM_CP   = 8,
    parameter  int TMO_BITS = CP_SCHED_TMO_BITS_C,
    localparam int SEL_W    = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   trig_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [NUM_CP-1:0]      en_i,
    input  logic                   abort_i,
    output logic [NUM_CP-1:0]      cp_start_o,
    input  logic [NUM_CP-1:0]      cp_valid_i,
    input  logic [NUM_CP*XLEN-1:0] cp_res_i,
    output logic [XLEN-1:0]        res_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   exc_o
);

    cp_sched_state_t     state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TMO_BITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NUM_CP-1:0]   start_d;
    logic [XLEN-1:0]     res_d;
    logic                done_d, exc_d;
    logic                slot_legal;
    logic                sel_valid;
    logic [XLEN-1:0]     sel_res;

    cellrv32_cpu_cp_resmux #(
        .XLEN   (XLEN),
        .NUM_CP (NUM_CP)
    ) u_resmux (
        .sel_i   (sel_q),
        .valid_i (cp_valid_i),
        .res_i   (cp_res_i),
        .valid_o (sel_valid),
        .res_o   (sel_res)
    );

    assign slot_legal = (32'(sel_i) < NUM_CP) && en_i[sel_i];
    assign busy_o     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + TMO_BITS'(1);
        start_d = cp_start_o;
        res_d   = res_o;
        done_d  = 1'b0;
        exc_d   = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            start_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig_i) begin
                        if (slot_legal) begin
                            sel_d   = sel_i;
                            cnt_d   = '0;
                            start_d = NUM_CP'(1) << sel_i;
                            state_d = RUN;
                        end else begin
                            exc_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // valid beats a timeout occurring on the same edge
                    if (sel_valid) begin
                        state_d = CAPT;
                        start_d = '0;
                    end else if (&cnt_inc) begin
                        state_d = IDLE;
                        start_d = '0;
                        exc_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                CAPT: begin
                    res_d   = sel_res;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    start_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            cp_start_o <= '0;
            res_o      <= '0;
            done_o     <= 1'b0;
            exc_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            cp_start_o <= start_d;
            res_o      <= res_d;
            done_o     <= done_d;
            exc_o      <= exc_d;
        end
    end

endmodule

// File: doc/cellrv32_cpu_cp_sched.md
Name: cellrv32_cpu_cp_sched

Overview:
Co-processor dispatcher between the CPU control unit and up to NUM_CP execution co-processors (conditional ops, shifter, mul/div, bit-manip, ...).
- Validates the requested co-processor slot and raises its start line.
- Waits for that slot's valid, captures the result one cycle later and returns it to the CPU with a done pulse.
- Guards every operation with a timeout and supports abort on pipeline flush.

Parameters:
XLEN, 32, data path width
NUM_CP, 8, number of co-processor slots (1..16)
TMO_BITS, 7, timeout counter width; timeout fires after 2**TMO_BITS-1 cycles in RUN

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  asynchronous reset, active-low
trig_i  in  1  CPU request to execute a co-processor operation (sampled only in IDLE)
sel_i  in  $clog2(NUM_CP)  co-processor slot index, sampled with trig_i
en_i  in  NUM_CP  implemented-slot mask (static configuration)
abort_i  in  1  pipeline flush; cancels any operation
cp_start_o  out  NUM_CP  one-hot start; level held for the whole RUN state
cp_valid_i  in  NUM_CP  per-slot valid; may be combinational from start
cp_res_i  in  NUM_CP*XLEN  per-slot results, slot n at [n*XLEN +: XLEN]; registered by the co-processor
res_o  out  XLEN  captured result, held until the next capture
done_o  out  1  one-cycle pulse: res_o is valid
busy_o  out  1  high in any state other than IDLE
exc_o  out  1  one-cycle pulse: illegal slot or timeout

Behaviour:
- Reset (rstn_i low, asynchronous): state = IDLE, cp_start_o = 0, res_o = 0, done_o = 0, exc_o = 0, timeout counter = 0, latched slot = 0.
- Outputs are registered except busy_o, which is decoded from state. done_o and exc_o are never high together.
- States: IDLE, RUN, CAPT.
- IDLE:
  - trig_i with sel_i >= NUM_CP or en_i[sel_i] = 0: exc_o pulses in the next cycle; stay in IDLE; cp_start_o stays 0.
  - trig_i with a legal slot: latch sel_i, clear the counter, go to RUN. cp_start_o[sel] is high from the next cycle.
- RUN:
  - cp_start_o[sel] held high; the counter increments each cycle.
  - cp_valid_i[sel] high at edge k: go to CAPT; cp_start_o drops to 0.
  - Valid bits of non-selected slots are ignored.
- CAPT:
  - At the next edge (k+1): res_o <= cp_res_i slice of the latched slot; done_o pulses for one cycle; go to IDLE.
  - Rationale: co-processors register their result on the edge where valid is sampled, so the result is stable in the following cycle.
- Minimum latency: trig cycle 0 -> start cycle 1 -> (combinational valid in cycle 1) CAPT cycle 2 -> done_o and res_o in cycle 3.
- Timeout: counter reaches all-ones in RUN with no valid -> exc_o pulses next cycle, cp_start_o drops, go to IDLE, res_o unchanged. Valid in the same cycle the counter saturates wins; the capture proceeds normally.
- Abort: abort_i high in any state -> IDLE next cycle, cp_start_o = 0, no done_o, no exc_o, res_o unchanged.
  - abort_i together with valid or timeout: abort wins.
  - abort_i together with trig_i in IDLE: trig_i is ignored (no exc_o).
- trig_i outside IDLE is ignored; there is no queueing.
- Back-to-back operation: trig_i may be asserted in the same cycle done_o is high (state already IDLE).

Decomposition:
- Shared package (cellrv32_package):
  - cp_sched_state_t enum {IDLE, RUN, CAPT}.
  - Constant CP_SCHED_TMO_BITS_C = 7.
  - Slot-index constants for each co-processor (CP_SEL_SHIFT_C, CP_SEL_MULDIV_C, CP_SEL_COND_C, ...).
- One sub-module: cellrv32_cpu_cp_resmux, a purely combinational NUM_CP-to-1 XLEN result/valid selector indexed by the latched slot. The FSM, counter and registers stay in the top module.

Test Plan:
- Legal 1-cycle op: en_i = 8'hFF, trig_i with sel_i = 3; slot 3 valid = start (combinational), result 32'hDEADBEEF registered -> cp_start_o = 8'h08 in cycle 1 only, done_o in cycle 3, res_o = 32'hDEADBEEF, exc_o stays 0.
- Illegal slot: en_i = 8'h0F, trig_i with sel_i = 5 -> exc_o pulses for one cycle, cp_start_o stays 8'h00, busy_o stays 0, res_o unchanged.
- Timeout: TMO_BITS = 7, sel_i = 2, valid never asserted -> cp_start_o[2] high for 127 cycles, then exc_o pulses once, state returns to IDLE, no done_o.
- Multi-cycle op with noise: sel_i = 1, slot 1 valid after 34 cycles, other slots toggle valid throughout -> done_o exactly once, res_o = slot 1 value (32'h0000_1234), no early completion.
- Abort races: abort_i in the same cycle as slot valid -> no done_o, no exc_o. Then trig_i in the same cycle as abort_i in IDLE -> ignored. A following trig_i completes normally.
- Async reset mid-RUN: rstn_i low between edges while cp_start_o = 8'h40 -> all outputs drop to 0 immediately; after release a new op with sel_i = 0 completes with 3-cycle latency.
